// File: rtl/niosii_sysid_checker_pkg.sv
// Shared definitions for the system-ID checker.
// The interconnect generator uses the same package, so the expected ID and
// timestamp defaults have a single source.
//   state_e            - checker FSM states
//   SYSID_ADDR_*       - word addresses inside the system-ID slave
//   DEFAULT_EXPECTED_* - build-time values the hardware must report
package niosii_sysid_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_RD_TS,
    ST_BACKOFF,
    ST_CHECK,
    ST_DONE
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1396825483;

  // A check counts as in progress from the first read until the result is
  // registered.
  function automatic logic is_busy_state(state_e s);
    return (s == ST_RD_ID) || (s == ST_RD_TS) || (s == ST_BACKOFF) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/niosii_sysid_checker_if.sv
// Avalon-MM read-only channel between the checker (master) and the
// system-ID slave / interconnect (slave).
//   avm_address     - 0 = ID word, 1 = timestamp word
//   avm_read        - read strobe, held until accepted
//   avm_waitrequest - stall from the slave side
//   avm_readdata    - valid when avm_read && !avm_waitrequest
interface niosii_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/niosii_sysid_checker_wait_timer.sv
// Saturating stall counter for one read attempt.
//   clock, reset_n - system clock, synchronous active-low reset
//   clear_i        - restart counting (new attempt or word accepted)
//   inc_i          - this cycle is a stalled read cycle
//   expired_o      - this stalled cycle is the LIMIT-th of the attempt
module niosii_sysid_checker_wait_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] count_q;

  // NOTE: sequential state uses nonblocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != W'(LIMIT))) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Flag the stall that brings the count to LIMIT so the FSM can drop the
  // strobe on that same edge.
  assign expired_o = inc_i && (count_q >= W'(LIMIT - 1));

endmodule

// File: rtl/niosii_sysid_checker.sv
// Avalon-MM master that reads the system-ID slave (ID word, then timestamp
// word) once after every reset and again on each start pulse, and reports
// whether both words match the build-time values.
//   clock, reset_n   - system clock, synchronous active-low reset
//   start            - one-cycle pulse, honoured in IDLE or DONE only
//   avm              - Avalon-MM master read channel
//   busy / done      - check in progress / result valid (held)
//   id_ok / ts_ok    - captured word equals its expected value
//   timeout_err      - a word exhausted its retries
//   captured_id / ts - last words read from the slave
// Every output comes straight from a register.
module niosii_sysid_checker
  import niosii_sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  niosii_sysid_checker_if.master avm,
  output logic                   busy,
  output logic                   done,
  output logic                   id_ok,
  output logic                   ts_ok,
  output logic                   timeout_err,
  output logic [31:0]            captured_id,
  output logic [31:0]            captured_ts
);

  state_e      state_q, state_d;
  logic        auto_run_q, auto_run_d;
  logic [3:0]  retry_q, retry_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_address_q, avm_address_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_err_q, timeout_err_d;
  logic [31:0] captured_id_q, captured_id_d;
  logic [31:0] captured_ts_q, captured_ts_d;

  logic in_read, accept, timer_expired;

  assign in_read = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);
  assign accept  = avm_read_q && !avm.avm_waitrequest;

  // Counting restarts whenever the strobe is not up (backoff, idle) and
  // when a word is accepted, so each attempt gets a full window.
  niosii_sysid_checker_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear_i   (!in_read || accept),
    .inc_i     (in_read && avm_read_q && avm.avm_waitrequest),
    .expired_o (timer_expired)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      auto_run_q    <= 1'b1;
      retry_q       <= '0;
      avm_read_q    <= 1'b0;
      avm_address_q <= SYSID_ADDR_ID;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      captured_id_q <= '0;
      captured_ts_q <= '0;
    end else begin
      state_q       <= state_d;
      auto_run_q    <= auto_run_d;
      retry_q       <= retry_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      id_ok_q       <= id_ok_d;
      ts_ok_q       <= ts_ok_d;
      timeout_err_q <= timeout_err_d;
      captured_id_q <= captured_id_d;
      captured_ts_q <= captured_ts_d;
    end
  end

  // NOTE: every variable gets its hold value before the case statement so
  // no path through the block leaves one unassigned (no inferred latch).
  always_comb begin
    state_d       = state_q;
    auto_run_d    = auto_run_q;
    retry_d       = retry_q;
    avm_read_d    = avm_read_q;
    avm_address_d = avm_address_q;
    id_ok_d       = id_ok_q;
    ts_ok_d       = ts_ok_q;
    timeout_err_d = timeout_err_q;
    captured_id_d = captured_id_q;
    captured_ts_d = captured_ts_q;

    unique case (state_q)
      ST_IDLE: begin
        if (auto_run_q || start) begin
          auto_run_d    = 1'b0;
          retry_d       = '0;
          avm_read_d    = 1'b1;
          avm_address_d = SYSID_ADDR_ID;
          state_d       = ST_RD_ID;
        end
      end

      ST_RD_ID, ST_RD_TS: begin
        if (accept) begin
          retry_d = '0;
          if (state_q == ST_RD_ID) begin
            captured_id_d = avm.avm_readdata;
            avm_address_d = SYSID_ADDR_TS;
            state_d       = ST_RD_TS;
          end else begin
            captured_ts_d = avm.avm_readdata;
            avm_read_d    = 1'b0;
            state_d       = ST_CHECK;
          end
        end else if (timer_expired) begin
          avm_read_d = 1'b0;
          if (retry_q == 4'(MAX_RETRIES)) begin
            timeout_err_d = 1'b1;
            id_ok_d       = 1'b0;
            ts_ok_d       = 1'b0;
            state_d       = ST_DONE;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = ST_BACKOFF;
          end
        end
      end

      // The address register still names the word that timed out.
      ST_BACKOFF: begin
        avm_read_d = 1'b1;
        state_d    = (avm_address_q == SYSID_ADDR_TS) ? ST_RD_TS : ST_RD_ID;
      end

      ST_CHECK: begin
        id_ok_d = (captured_id_q == EXPECTED_ID);
        ts_ok_d = (captured_ts_q == EXPECTED_TIMESTAMP);
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (start) begin
          id_ok_d       = 1'b0;
          ts_ok_d       = 1'b0;
          timeout_err_d = 1'b0;
          retry_d       = '0;
          avm_read_d    = 1'b1;
          avm_address_d = SYSID_ADDR_ID;
          state_d       = ST_RD_ID;
        end
      end

      default: begin
        avm_read_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase

    // Status flags follow the state being entered so they are registered.
    busy_d = is_busy_state(state_d);
    done_d = (state_d == ST_DONE);
  end

  assign avm.avm_read    = avm_read_q;
  assign avm.avm_address = avm_address_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign id_ok           = id_ok_q;
  assign ts_ok           = ts_ok_q;
  assign timeout_err     = timeout_err_q;
  assign captured_id     = captured_id_q;
  assign captured_ts     = captured_ts_q;

endmodule

// File: tb/tb_niosii_sysid_checker.sv
// Bench for the system-ID checker. Two instances: A with default timing
// (long timeout, 3 retries) and B with TIMEOUT_CYCLES=4, MAX_RETRIES=1.
// Each instance sees a slave that stalls a programmable number of read
// cycles per word; expected latency and flags come from an arithmetic model
// of the timing rules.
module tb_niosii_sysid_checker;
  import niosii_sysid_checker_pkg::*;

  localparam int T_A = 255;
  localparam int R_A = 3;
  localparam int T_B = 4;
  localparam int R_B = 1;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1396825483;

  typedef struct packed {
    int latency;
    bit timeout;
    bit ts_word;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_a, rst_b, start_a, start_b;
  niosii_sysid_checker_if bus_a ();
  niosii_sysid_checker_if bus_b ();

  logic        busy_a, done_a, id_ok_a, ts_ok_a, to_a;
  logic        busy_b, done_b, id_ok_b, ts_ok_b, to_b;
  logic [31:0] cid_a, cts_a, cid_b, cts_b;

  niosii_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES(T_A), .MAX_RETRIES(R_A)
  ) dut_a (
    .clock(clock), .reset_n(rst_a), .start(start_a), .avm(bus_a),
    .busy(busy_a), .done(done_a), .id_ok(id_ok_a), .ts_ok(ts_ok_a),
    .timeout_err(to_a), .captured_id(cid_a), .captured_ts(cts_a)
  );

  niosii_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES(T_B), .MAX_RETRIES(R_B)
  ) dut_b (
    .clock(clock), .reset_n(rst_b), .start(start_b), .avm(bus_b),
    .busy(busy_b), .done(done_b), .id_ok(id_ok_b), .ts_ok(ts_ok_b),
    .timeout_err(to_b), .captured_id(cid_b), .captured_ts(cts_b)
  );

  // Slave models: while the strobe is up, stall for stall_x[addr] read
  // cycles in total (across attempts), then return mem_x[addr]. Data is
  // garbage during stalls and waitrequest is random when no read is up.
  logic [31:0] mem_a [2];
  logic [31:0] mem_b [2];
  int          stall_a [2];
  int          stall_b [2];

  always @(negedge clock) begin
    if (bus_a.avm_read === 1'b1) begin
      if (stall_a[bus_a.avm_address] > 0) begin
        bus_a.avm_waitrequest = 1'b1;
        bus_a.avm_readdata    = $urandom;
        stall_a[bus_a.avm_address] = stall_a[bus_a.avm_address] - 1;
      end else begin
        bus_a.avm_waitrequest = 1'b0;
        bus_a.avm_readdata    = mem_a[bus_a.avm_address];
      end
    end else begin
      bus_a.avm_waitrequest = 1'($urandom_range(0, 1));
      bus_a.avm_readdata    = $urandom;
    end
  end

  always @(negedge clock) begin
    if (bus_b.avm_read === 1'b1) begin
      if (stall_b[bus_b.avm_address] > 0) begin
        bus_b.avm_waitrequest = 1'b1;
        bus_b.avm_readdata    = $urandom;
        stall_b[bus_b.avm_address] = stall_b[bus_b.avm_address] - 1;
      end else begin
        bus_b.avm_waitrequest = 1'b0;
        bus_b.avm_readdata    = mem_b[bus_b.avm_address];
      end
    end else begin
      bus_b.avm_waitrequest = 1'($urandom_range(0, 1));
      bus_b.avm_readdata    = $urandom;
    end
  end

  // Observation mux: sel picks which instance the generic tasks look at.
  bit          sel;
  logic        o_busy, o_done, o_id_ok, o_ts_ok, o_to, o_read, o_addr;
  logic [31:0] o_cid, o_cts;
  always_comb begin
    o_busy  = sel ? busy_b  : busy_a;
    o_done  = sel ? done_b  : done_a;
    o_id_ok = sel ? id_ok_b : id_ok_a;
    o_ts_ok = sel ? ts_ok_b : ts_ok_a;
    o_to    = sel ? to_b    : to_a;
    o_read  = sel ? bus_b.avm_read    : bus_a.avm_read;
    o_addr  = sel ? bus_b.avm_address : bus_a.avm_address;
    o_cid   = sel ? cid_b : cid_a;
    o_cts   = sel ? cts_b : cts_a;
  end

  int          checks   = 0;
  int          failures = 0;
  int          exp_lat;
  bit          exp_to, exp_id_ok, exp_ts_ok;
  logic [31:0] exp_cap_id [2];
  logic [31:0] exp_cap_ts [2];

  // Timing model. Cycle 1 is the edge that launches the ID read. A word
  // stalled s cycles fails floor(s/t) attempts (each t stalls + 1 backoff)
  // and is accepted (s mod t) cycles into the next one; more than m failed
  // attempts ends the check with a timeout on the m+1-th expiry.
  function automatic exp_t model(int t, int m, int s_id, int s_ts);
    exp_t r;
    int launch_edge = 1;
    int s, f;
    r = '0;
    for (int w = 0; w < 2; w++) begin
      s = (w == 0) ? s_id : s_ts;
      f = s / t;
      if (f > m) begin
        r.latency = launch_edge + m * (t + 1) + t;
        r.timeout = 1'b1;
        r.ts_word = (w == 1);
        return r;
      end
      launch_edge += f * (t + 1) + (s % t) + 1;
    end
    r.latency = launch_edge + 1;  // CHECK edge, then DONE
    return r;
  endfunction

  // Leaves the bench at the negedge just before cycle 1 of a new check.
  task automatic launch(input bit by_start);
    @(negedge clock);
    if (by_start) begin
      if (sel) start_b = 1'b1; else start_a = 1'b1;
    end else begin
      if (sel) rst_b = 1'b0; else rst_a = 1'b0;
      @(negedge clock);
      if (sel) rst_b = 1'b1; else rst_a = 1'b1;
      exp_cap_id[sel] = '0;
      exp_cap_ts[sel] = '0;
    end
  endtask

  task automatic arm(input int s_id, input int s_ts, input logic [31:0] id_val,
                     input logic [31:0] ts_val);
    exp_t e;
    if (sel) begin
      mem_b[0] = id_val; mem_b[1] = ts_val; stall_b[0] = s_id; stall_b[1] = s_ts;
      e = model(T_B, R_B, s_id, s_ts);
    end else begin
      mem_a[0] = id_val; mem_a[1] = ts_val; stall_a[0] = s_id; stall_a[1] = s_ts;
      e = model(T_A, R_A, s_id, s_ts);
    end
    exp_lat   = e.latency;
    exp_to    = e.timeout;
    exp_id_ok = !e.timeout && (id_val == EXP_ID);
    exp_ts_ok = !e.timeout && (ts_val == EXP_TS);
    if (!e.timeout || e.ts_word) exp_cap_id[sel] = id_val;
    if (!e.timeout) exp_cap_ts[sel] = ts_val;
  endtask

  // Called at the negedge after cycle 'already'; waits for done and checks
  // the result against the model.
  task automatic finish_check(input string name, input int already);
    int lat = 0;
    bit seen = 1'b0;
    for (int c = already + 1; c <= exp_lat + 20; c++) begin
      @(negedge clock);
      start_a = 1'b0;
      start_b = 1'b0;
      if (o_done === 1'b1) begin
        lat  = c;
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || lat != exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d (done seen=%0d) expected %0d", name, lat, seen, exp_lat);
    end
    checks++;
    if (o_to !== exp_to) begin
      failures++;
      $display("FAIL %s timeout_err: got %b expected %b", name, o_to, exp_to);
    end
    checks++;
    if (o_id_ok !== exp_id_ok || o_ts_ok !== exp_ts_ok) begin
      failures++;
      $display("FAIL %s ok flags: got id_ok=%b ts_ok=%b expected %b %b",
               name, o_id_ok, o_ts_ok, exp_id_ok, exp_ts_ok);
    end
    checks++;
    if (o_busy !== 1'b0 || o_read !== 1'b0) begin
      failures++;
      $display("FAIL %s idle bus: got busy=%b avm_read=%b expected 0 0", name, o_busy, o_read);
    end
    checks++;
    if (o_cid !== exp_cap_id[sel] || o_cts !== exp_cap_ts[sel]) begin
      failures++;
      $display("FAIL %s captured: got %h/%h expected %h/%h",
               name, o_cid, o_cts, exp_cap_id[sel], exp_cap_ts[sel]);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy_a, done_a, id_ok_a, ts_ok_a, to_a, bus_a.avm_read} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags_a: got %b expected 000000",
               {busy_a, done_a, id_ok_a, ts_ok_a, to_a, bus_a.avm_read});
    end
    checks++;
    if (cid_a !== 32'd0 || cts_a !== 32'd0) begin
      failures++;
      $display("FAIL reset_captured_a: got %h/%h expected 0/0", cid_a, cts_a);
    end
    checks++;
    if ({busy_b, done_b, id_ok_b, ts_ok_b, to_b, bus_b.avm_read} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags_b: got %b expected 000000",
               {busy_b, done_b, id_ok_b, ts_ok_b, to_b, bus_b.avm_read});
    end
    checks++;
    if (cid_b !== 32'd0 || cts_b !== 32'd0) begin
      failures++;
      $display("FAIL reset_captured_b: got %h/%h expected 0/0", cid_b, cts_b);
    end
  endtask

  task automatic test_basic();
    sel = 1'b0;
    launch(1'b0);
    arm(0, 0, EXP_ID, EXP_TS);
    finish_check("basic", 0);
  endtask

  task automatic test_id_mismatch();
    sel = 1'b0;
    launch(1'b1);
    arm(0, 0, 32'h0000_0001, EXP_TS);
    finish_check("id_mismatch", 0);
  endtask

  task automatic test_id_stall();
    sel = 1'b0;
    launch(1'b1);
    arm(10, 0, EXP_ID, EXP_TS);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clock);
      start_a = 1'b0;
      checks++;
      if (o_read !== 1'b1 || o_addr !== SYSID_ADDR_ID) begin
        failures++;
        $display("FAIL id_stall cycle %0d: got read=%b addr=%b expected 1 0", c, o_read, o_addr);
      end
    end
    finish_check("id_stall", 11);
  endtask

  task automatic test_restart();
    sel = 1'b0;
    launch(1'b1);
    arm(0, 6, EXP_ID, EXP_TS + 32'($urandom_range(1, 1000)));
    @(negedge clock);
    start_a = 1'b0;
    checks++;
    if ({o_done, o_id_ok, o_ts_ok, o_to, o_busy} !== 5'b00001) begin
      failures++;
      $display("FAIL restart_clear: got done/id/ts/err/busy=%b expected 00001",
               {o_done, o_id_ok, o_ts_ok, o_to, o_busy});
    end
    @(negedge clock);
    start_a = 1'b1;  // must be ignored while busy
    @(negedge clock);
    start_a = 1'b0;
    finish_check("restart", 3);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      launch(1'b1);
      arm($urandom_range(0, 15), $urandom_range(0, 15),
          ($urandom_range(0, 1) != 0) ? EXP_ID : 32'($urandom),
          ($urandom_range(0, 1) != 0) ? EXP_TS : 32'($urandom));
      finish_check("back_to_back", 0);
    end
  endtask

  task automatic test_reset_mid_read();
    sel = 1'b0;
    launch(1'b1);
    arm(0, 50, 32'h1234_5678, EXP_TS);
    repeat (3) begin
      @(negedge clock);
      start_a = 1'b0;
    end
    checks++;
    if (o_read !== 1'b1 || o_addr !== SYSID_ADDR_TS) begin
      failures++;
      $display("FAIL mid_read_state: got read=%b addr=%b expected 1 1", o_read, o_addr);
    end
    rst_a = 1'b0;
    @(negedge clock);
    checks++;
    if ({o_read, o_busy, o_done, o_id_ok, o_ts_ok, o_to} !== 6'b0) begin
      failures++;
      $display("FAIL mid_read_reset: got read/busy/done/id/ts/err=%b expected 000000",
               {o_read, o_busy, o_done, o_id_ok, o_ts_ok, o_to});
    end
    checks++;
    if (o_cid !== 32'd0 || o_cts !== 32'd0) begin
      failures++;
      $display("FAIL mid_read_captured: got %h/%h expected 0/0", o_cid, o_cts);
    end
    rst_a = 1'b1;
    exp_cap_id[0] = '0;
    exp_cap_ts[0] = '0;
    arm(0, 0, EXP_ID, EXP_TS);
    finish_check("reset_rerun", 0);
  endtask

  task automatic test_timeout();
    int rises = 0, lows = 0, highs = 0, bad_addr = 0;
    logic prev = 1'b0;
    sel = 1'b1;
    launch(1'b0);
    arm(1000, 0, EXP_ID, EXP_TS);
    for (int c = 1; c < exp_lat; c++) begin
      @(negedge clock);
      if (o_read === 1'b1) begin
        highs++;
        if (!prev) rises++;
        if (o_addr !== SYSID_ADDR_ID) bad_addr++;
      end else begin
        lows++;
      end
      prev = o_read;
    end
    checks++;
    if (rises != R_B + 1 || lows != R_B || highs != (R_B + 1) * T_B) begin
      failures++;
      $display("FAIL timeout_attempts: got attempts=%0d drops=%0d high=%0d expected %0d %0d %0d",
               rises, lows, highs, R_B + 1, R_B, (R_B + 1) * T_B);
    end
    checks++;
    if (bad_addr != 0) begin
      failures++;
      $display("FAIL timeout_addr: got %0d cycles off address 0 expected 0", bad_addr);
    end
    finish_check("timeout", exp_lat - 1);
  endtask

  task automatic test_random_retry();
    sel = 1'b1;
    for (int i = 0; i < 8; i++) begin
      launch(1'b1);
      arm($urandom_range(0, 10), $urandom_range(0, 10),
          ($urandom_range(0, 1) != 0) ? EXP_ID : 32'($urandom),
          ($urandom_range(0, 1) != 0) ? EXP_TS : 32'($urandom));
      finish_check("random_retry", 0);
    end
  endtask

  initial begin
    rst_a   = 1'b0;
    rst_b   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    sel     = 1'b0;
    exp_cap_id[0] = '0; exp_cap_id[1] = '0;
    exp_cap_ts[0] = '0; exp_cap_ts[1] = '0;
    stall_a[0] = 0; stall_a[1] = 0; stall_b[0] = 0; stall_b[1] = 0;
    repeat (3) @(negedge clock);
    test_reset();
    test_basic();
    test_id_mismatch();
    test_id_stall();
    test_restart();
    test_back_to_back();
    test_reset_mid_read();
    test_timeout();
    test_random_retry();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
